ram_port_arbiter: RTL

Arbitrates the core's single shared RAM port between the instruction-fetch requester (`if_stage`) and the load/store requester (`mem_stage`). It registers one request at a time, drives it onto the RAM port, and returns the read data or completion to the owning requester. A timeout watchdog aborts any RAM transaction that is never acknowledged. It sits between the pipeline stages and the RAM model in `SimTop`.

---
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of ram_port_arbiter, grouped with slave (arbiter) and master (environment) views.
// Handshake: *_req is held with stable fields until the one-cycle *_ack; ram_req is held until ram_ack or abort.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_wmask;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_wmask;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata, mem_err,
        output ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
        input  ram_ack, ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata, mem_err,
        input  ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store, with a no-ack watchdog.
// Define ARB_RR_EN for round-robin arbitration; default is MEM priority with an IF starvation guard.
module ram_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    ram_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} state_e;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d, busy_q, busy_d;
    logic              ram_req_q, ram_req_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, ram_wmask_q, ram_wmask_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic              mem_ack_q, mem_ack_d, mem_err_q, mem_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              pick_mem;

`ifdef ARB_RR_EN
    // Simultaneous requests go away from the previous owner.
    assign pick_mem = bus.mem_req && (!bus.if_req || !owner_q);
`else
    localparam int SV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    logic [SV_W-1:0] starve_q, starve_d;

    assign pick_mem = bus.mem_req && (!bus.if_req || (starve_q != SV_W'(STARVE_MAX)));

    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE && (bus.if_req || bus.mem_req)) begin
            if (!pick_mem)       starve_d = '0;
            else if (bus.if_req) starve_d = starve_q + SV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wmask_d = ram_wmask_q;
        wd_d        = wd_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        mem_ack_d   = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    owner_d     = pick_mem;
                    ram_req_d   = 1'b1;
                    ram_we_d    = pick_mem && bus.mem_we;
                    ram_addr_d  = pick_mem ? bus.mem_addr : bus.if_addr;
                    ram_wdata_d = pick_mem ? bus.mem_wdata : '0;
                    ram_wmask_d = pick_mem ? bus.mem_wmask : '0;
                    wd_d        = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack arriving in the expiring cycle still completes normally.
                if (bus.ram_ack || (wd_q == WD_W'(TIMEOUT - 1))) begin
                    ram_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_q) begin
                        mem_ack_d   = 1'b1;
                        mem_err_d   = !bus.ram_ack;
                        mem_rdata_d = bus.ram_ack ? bus.ram_rdata : '0;
                    end else begin
                        if_ack_d    = 1'b1;
                        if_err_d    = !bus.ram_ack;
                        if_rdata_d  = bus.ram_ack ? bus.ram_rdata : '0;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wmask_q <= '0;
            wd_q        <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wmask_q <= ram_wmask_d;
            wd_q        <= wd_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_wmask = ram_wmask_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign busy          = busy_q;
    assign owner         = owner_q;
    assign dbg_state_o   = state_q;
endmodule
